// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer
// Multi-operand unsigned accumulator built around a single shared 3:2
// carry-save stage. Each accepted operand is folded into a redundant
// {sum, carry} pair in one cycle. The carry-propagate add happens only once
// per set, in the RESOLVE state, so the per-operand path stays one full-adder
// deep. The result, operand count and overflow flag are presented on a
// valid/ready output. They are held stable until the consumer takes them.

module csa_accum_sequencer #(
    parameter int IN_W    = 21,
    parameter int ACC_W   = 23,
    parameter int MAX_OPS = 16,
    localparam int CNT_W  = $clog2(MAX_OPS + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] op_cnt,
    output logic             ovf
);

    // Sequencer states: first operand, further operands, final add, result held
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

    // Operand count saturates one above the limit so that an overflowing set
    // is still distinguishable from a full, legal one.
    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(MAX_OPS);
    localparam logic [CNT_W:0]   CNT_SAT_W = (CNT_W + 1)'(MAX_OPS + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_OPS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W - 1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------

    // Operand widened to the accumulator width (unsigned)
    function automatic logic [ACC_W-1:0] zext(input logic [IN_W-1:0] d);
        zext = ACC_W'(d);
    endfunction

    // 3:2 compressor sum output: bitwise parity of the three inputs
    function automatic logic [ACC_W-1:0] csa_sum(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] s,
        input logic [ACC_W-1:0] c
    );
        csa_sum = a ^ s ^ c;
    endfunction

    // 3:2 compressor carry output: bitwise majority moved up one place;
    // the carry out of the MSB falls off, which gives mod 2^ACC_W wrapping
    function automatic logic [ACC_W-1:0] csa_carry(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] s,
        input logic [ACC_W-1:0] c
    );
        logic [ACC_W-1:0] maj;
        maj       = (a & s) | (a & c) | (s & c);
        csa_carry = {maj[ACC_W-2:0], 1'b0};
    endfunction

    // Saturating increment of the operand counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W:0] plus_one);
        if (plus_one > CNT_SAT_W) begin
            sat_inc = CNT_SAT;
        end else begin
            sat_inc = plus_one[CNT_W-1:0];
        end
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_r;
    state_t            next_state_s;
    logic [ACC_W-1:0]  sum_r;
    logic [ACC_W-1:0]  carry_r;
    logic [ACC_W-1:0]  sum_next_s;
    logic [ACC_W-1:0]  carry_next_s;
    logic [ACC_W-1:0]  out_data_r;
    logic [ACC_W-1:0]  out_data_next_s;
    logic [CNT_W-1:0]  op_cnt_r;
    logic [CNT_W-1:0]  op_cnt_next_s;
    logic              ovf_r;
    logic              ovf_next_s;
    logic              in_ready_r;
    logic              in_ready_next_s;
    logic              out_valid_r;
    logic              out_valid_next_s;

    logic              accept_s;
    logic              handshake_s;
    logic              load_first_s;
    logic              fold_s;
    logic              resolve_s;
    logic [ACC_W-1:0]  operand_s;
    logic [CNT_W:0]    cnt_plus_one_s;

    // in_ready is held low while reset is asserted, whatever the register holds
    assign in_ready    = in_ready_r & ~rst;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign op_cnt      = op_cnt_r;
    assign ovf         = ovf_r;

    assign accept_s       = in_valid & in_ready;
    assign handshake_s    = out_valid_r & out_ready;
    assign operand_s      = zext(in_data);
    assign cnt_plus_one_s = {1'b0, op_cnt_r} + {{CNT_W{1'b0}}, 1'b1};

    // Next-state decode and per-state datapath strobes
    always_comb begin
        next_state_s = state_r;
        load_first_s = 1'b0;
        fold_s       = 1'b0;
        resolve_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_first_s = 1'b1;
                    if (in_last) begin
                        next_state_s = RESOLVE;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    fold_s = 1'b1;
                    if (in_last) begin
                        next_state_s = RESOLVE;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end else begin
                    next_state_s = ACCUM;
                end
            end
            RESOLVE: begin
                resolve_s    = 1'b1;
                next_state_s = OUT;
            end
            OUT: begin
                if (handshake_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = OUT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the upcoming state
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        if ((next_state_s == IDLE) || (next_state_s == ACCUM)) begin
            in_ready_next_s = 1'b1;
        end else begin
            in_ready_next_s = 1'b0;
        end
        if (next_state_s == OUT) begin
            out_valid_next_s = 1'b1;
        end else begin
            out_valid_next_s = 1'b0;
        end
    end

    // Carry-save fold, operand counting and final carry-propagate add
    always_comb begin
        sum_next_s      = sum_r;
        carry_next_s    = carry_r;
        op_cnt_next_s   = op_cnt_r;
        ovf_next_s      = ovf_r;
        out_data_next_s = out_data_r;
        if (load_first_s) begin
            // First beat of a set: the redundant pair starts as {operand, 0}
            sum_next_s    = operand_s;
            carry_next_s  = {ACC_W{1'b0}};
            op_cnt_next_s = CNT_ONE;
            ovf_next_s    = 1'b0;
        end else if (fold_s) begin
            sum_next_s    = csa_sum(operand_s, sum_r, carry_r);
            carry_next_s  = csa_carry(operand_s, sum_r, carry_r);
            op_cnt_next_s = sat_inc(cnt_plus_one_s);
            if (cnt_plus_one_s > CNT_LIMIT) begin
                ovf_next_s = 1'b1;
            end else begin
                ovf_next_s = ovf_r;
            end
        end else if (resolve_s) begin
            out_data_next_s = sum_r + carry_r;
        end else begin
            // No beat and nothing to resolve: every register holds
            sum_next_s = sum_r;
        end
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sum_r       <= {ACC_W{1'b0}};
            carry_r     <= {ACC_W{1'b0}};
            out_data_r  <= {ACC_W{1'b0}};
            op_cnt_r    <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            sum_r       <= sum_next_s;
            carry_r     <= carry_next_s;
            out_data_r  <= out_data_next_s;
            op_cnt_r    <= op_cnt_next_s;
            ovf_r       <= ovf_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer
// Directed bench for the carry-save accumulator sequencer. Expected sums are
// hand-computed constants or a simple running-sum model kept in the bench.

module tb_csa_accum_sequencer;

    localparam int IN_W    = 21;
    localparam int ACC_W   = 23;
    localparam int MAX_OPS = 16;
    localparam int CNT_W   = $clog2(MAX_OPS + 2);

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] op_cnt;
    logic             ovf;

    int n_checks;
    int n_pass;

    csa_accum_sequencer #(
        .IN_W    (IN_W),
        .ACC_W   (ACC_W),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .op_cnt    (op_cnt),
        .ovf       (ovf)
    );

    // 100 MHz style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report any difference
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and wait (bounded) until it is accepted
    task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 40) begin
            step();
            k++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", 32'd0, 32'd1);
        end
        step();
        in_valid = 1'b0;
        in_data  = {IN_W{1'b0}};
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a result, compare it, then take it with out_ready
    task automatic expect_result(input string tag, input logic [ACC_W-1:0] exp_data,
                                 input int exp_cnt, input logic exp_ovf);
        int k;
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(exp_data));
        check({tag, "_cnt"},   32'(op_cnt),    32'(exp_cnt));
        check({tag, "_ovf"},   32'(ovf),       32'(exp_ovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    // Send n copies of the same operand, last on the final one
    task automatic send_const_set(input int n, input logic [IN_W-1:0] d);
        for (int i = 0; i < n; i++) begin
            send_beat(d, (i == n - 1));
        end
    endtask

    logic [ACC_W-1:0] model_sum;
    logic [IN_W-1:0]  rnd_val;
    int               rnd_n;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = {IN_W{1'b0}};
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_op_cnt",    32'(op_cnt),    32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // T1: {3,5,7} with latency check around the last beat
        send_beat(21'd3, 1'b0);
        send_beat(21'd5, 1'b0);
        send_beat(21'd7, 1'b1);
        check("t1_resolve_no_valid", 32'(out_valid), 32'd0);
        check("t1_resolve_no_ready", 32'(in_ready),  32'd0);
        step();
        check("t1_valid_two_cycles", 32'(out_valid), 32'd1);
        expect_result("t1", 23'd15, 3, 1'b0);

        // T2: wrap behaviour of the accumulator
        send_const_set(4, 21'h1FFFFF);
        expect_result("t2_four", 23'd8388604, 4, 1'b0);
        send_const_set(5, 21'h1FFFFF);
        expect_result("t2_five", 23'd2097147, 5, 1'b0);

        // T3: single-operand set
        send_beat(21'h1FFFFF, 1'b1);
        expect_result("t3", 23'h1FFFFF, 1, 1'b0);

        // T4: back-pressure in OUT; a waiting operand is taken only after the handshake
        send_beat(21'd10, 1'b0);
        send_beat(21'd20, 1'b1);
        step();
        in_valid = 1'b1;
        in_data  = 21'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_data",  32'(out_data),  32'd30);
            check("t4_hold_ready", 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t4_ready_after_hs", 32'(in_ready),  32'd1);
        check("t4_valid_after_hs", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t4_next_taken", 32'(in_ready), 32'd0);
        step();
        check("t4_next_valid", 32'(out_valid), 32'd1);
        check("t4_next_data",  32'(out_data),  32'd1);
        check("t4_next_cnt",   32'(op_cnt),    32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // T5: operand-count limit and saturation
        send_const_set(16, 21'd1);
        expect_result("t5_sixteen", 23'd16, 16, 1'b0);
        send_const_set(17, 21'd1);
        expect_result("t5_seventeen", 23'd17, 17, 1'b1);
        send_beat(21'd2, 1'b1);
        expect_result("t5_after", 23'd2, 1, 1'b0);
        send_const_set(18, 21'd1);
        expect_result("t5_eighteen", 23'd18, 17, 1'b1);

        // T6: reset aborts an open set
        send_beat(21'd100, 1'b0);
        send_beat(21'd200, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        check("t6_cnt_cleared", 32'(op_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_output", 32'(out_valid), 32'd0);
            step();
        end
        send_beat(21'd9, 1'b1);
        expect_result("t6_nine", 23'd9, 1, 1'b0);

        // Random operand sets with random gaps against a running-sum model
        for (int s = 0; s < 5; s++) begin
            rnd_n     = int'($urandom_range(1, 20));
            model_sum = {ACC_W{1'b0}};
            for (int i = 0; i < rnd_n; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    in_data = IN_W'($urandom);
                    in_last = 1'b1;
                    step();
                end
                rnd_val   = IN_W'($urandom);
                model_sum = model_sum + ACC_W'(rnd_val);
                send_beat(rnd_val, (i == rnd_n - 1));
            end
            expect_result("rand", model_sum, (rnd_n > MAX_OPS) ? MAX_OPS + 1 : rnd_n,
                          (rnd_n > MAX_OPS));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
